// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble-serial adder scheduler.
package nibble_pkg;

    localparam int DEF_NIBBLES = 4;
    localparam int DEF_SETTLE  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_add_sched_if.sv
// Requester handshake, result bus and external nibble_adder hookup.
interface nibble_add_sched_if #(
    parameter int NIBBLES = nibble_pkg::DEF_NIBBLES
);
    localparam int W = 4 * NIBBLES;

    logic [1:0]   req;
    logic [W-1:0] a0, b0, a1, b1;
    logic         cin0, cin1;
    logic [1:0]   ack;
    logic [W-1:0] sum;
    logic         cout;
    logic         done;
    logic         done_id;
    logic         busy;
    logic [3:0]   add_a, add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;

    // Scheduler side.
    modport slave (
        input  req, a0, b0, cin0, a1, b1, cin1, add_s, add_cout,
        output ack, sum, cout, done, done_id, busy, add_a, add_b, add_cin
    );

    // Requesters plus the external adder.
    modport master (
        output req, a0, b0, cin0, a1, b1, cin1, add_s, add_cout,
        input  ack, sum, cout, done, done_id, busy, add_a, add_b, add_cin
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);
    // Pure combinational grant selection.
    always_comb begin
        valid_o = |req_i;
        case (req_i)
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = ~last_grant_i;
            default: grant_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/nibble_add_sched.sv
// Shares one external 4-bit adder between two requesters, walking the
// operands a nibble at a time and letting each nibble settle for SETTLE
// cycles before sampling the adder.
module nibble_add_sched
    import nibble_pkg::*;
#(
    parameter int NIBBLES = DEF_NIBBLES,
    parameter int SETTLE  = DEF_SETTLE
) (
    input  logic            clk,
    input  logic            rst_n,
    nibble_add_sched_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = cnt_w(SETTLE);
    localparam int NW = cnt_w(NIBBLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [NW-1:0] NIB_LAST = NW'(NIBBLES - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, b_q;
    logic [W-1:0]  shadow_q;      // result assembled nibble by nibble
    logic [W-1:0]  sum_q;
    logic          carry_q;
    logic          cout_q;
    logic          grant_q;
    logic          last_grant_q;
    logic          done_id_q;
    logic [CW-1:0] cnt_q;
    logic [NW-1:0] nib_q;
    logic          arb_grant;
    logic          arb_valid;
    logic          settle_end;

    rr_arb2 u_arb (
        .req_i       (bus.req),
        .last_grant_i(last_grant_q),
        .grant_o     (arb_grant),
        .valid_o     (arb_valid)
    );

    // Settling is timed purely by the cycle counter.
    assign settle_end = (state_q == ST_ADD) && (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (arb_valid) state_d = ST_ADD;
            ST_ADD:  if (settle_end && (nib_q == NIB_LAST)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch, nibble walk and result bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            shadow_q     <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;   // requester 0 wins the first tie
            done_id_q    <= 1'b0;
            cnt_q        <= '0;
            nib_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_q <= arb_grant;
                        a_q     <= arb_grant ? bus.a1 : bus.a0;
                        b_q     <= arb_grant ? bus.b1 : bus.b0;
                        carry_q <= arb_grant ? bus.cin1 : bus.cin0;
                        nib_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                ST_ADD: begin
                    if (cnt_q == CNT_LAST) begin
                        shadow_q[nib_q*4 +: 4] <= bus.add_s;
                        carry_q                <= bus.add_cout;
                        cnt_q                  <= '0;
                        if (nib_q != NIB_LAST) nib_q <= nib_q + NW'(1);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    sum_q        <= shadow_q;
                    cout_q       <= carry_q;
                    done_id_q    <= grant_q;
                    last_grant_q <= grant_q;
                end
                default: ;
            endcase
        end
    end

    // Outputs: adder drive only in ADD; the finished result is shown
    // straight from the shadow during DONE and held afterwards.
    always_comb begin
        bus.add_a   = 4'h0;
        bus.add_b   = 4'h0;
        bus.add_cin = 1'b0;
        bus.done    = 1'b0;
        bus.ack     = 2'b00;
        bus.busy    = (state_q != ST_IDLE);
        bus.sum     = sum_q;
        bus.cout    = cout_q;
        bus.done_id = done_id_q;
        case (state_q)
            ST_ADD: begin
                bus.add_a   = a_q[nib_q*4 +: 4];
                bus.add_b   = b_q[nib_q*4 +: 4];
                bus.add_cin = carry_q;
            end
            ST_DONE: begin
                bus.done    = 1'b1;
                bus.ack     = grant_q ? 2'b10 : 2'b01;
                bus.sum     = shadow_q;
                bus.cout    = carry_q;
                bus.done_id = grant_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nibble_add_sched.sv
// Directed bench for nibble_add_sched with a transaction-level model.
module tb_nibble_add_sched;
    localparam int NIB = 4;
    localparam int SET = 4;
    localparam int W   = 4 * NIB;
    localparam int TOT = NIB * SET;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    nibble_add_sched_if #(.NIBBLES(NIB)) bus ();

    nibble_add_sched #(.NIBBLES(NIB), .SETTLE(SET)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // Combinational nibble adder.
    assign {bus.add_cout, bus.add_s} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: one transaction at a time ----------------
    function automatic logic pick(input logic [1:0] r, input logic last);
        return (r == 2'b11) ? ~last : r[1];
    endfunction

    logic         m_busy, m_g, m_last, m_cin, h_cout, h_id;
    logic [W-1:0] m_a, m_b, h_sum;
    int           m_t;
    logic [W:0]   m_res;

    assign m_res = {1'b0, m_a} + {1'b0, m_b} + (W+1)'(m_cin);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_t <= 0; m_last <= 1'b1; m_g <= 1'b0;
            m_a <= '0; m_b <= '0; m_cin <= 1'b0;
            h_sum <= '0; h_cout <= 1'b0; h_id <= 1'b0;
        end else if (!m_busy) begin
            if (bus.req != 2'b00) begin
                m_busy <= 1'b1;
                m_t    <= 0;
                m_g    <= pick(bus.req, m_last);
                m_a    <= pick(bus.req, m_last) ? bus.a1 : bus.a0;
                m_b    <= pick(bus.req, m_last) ? bus.b1 : bus.b0;
                m_cin  <= pick(bus.req, m_last) ? bus.cin1 : bus.cin0;
            end
        end else if (m_t == TOT) begin
            m_busy <= 1'b0;
            m_last <= m_g;
            h_sum  <= m_res[W-1:0];
            h_cout <= m_res[W];
            h_id   <= m_g;
        end else begin
            m_t <= m_t + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        int          nib;
        logic [63:0] mask, ea, eb, ec;
        logic        ed, eadd;
        wait (cmp_en);
        forever begin
            @(negedge clk);
            ed   = m_busy && (m_t == TOT);
            eadd = m_busy && (m_t < TOT);
            nib  = m_t / SET;
            mask = (64'd1 << (4 * nib)) - 64'd1;
            ea   = eadd ? ((64'(m_a) >> (4 * nib)) & 64'hF) : 64'd0;
            eb   = eadd ? ((64'(m_b) >> (4 * nib)) & 64'hF) : 64'd0;
            ec   = eadd ? (((64'(m_a) & mask) + (64'(m_b) & mask) + 64'(m_cin)) >> (4 * nib)) : 64'd0;
            chk("busy",    64'(bus.busy),    64'(m_busy));
            chk("done",    64'(bus.done),    64'(ed));
            chk("ack",     64'(bus.ack),     ed ? (m_g ? 64'd2 : 64'd1) : 64'd0);
            chk("sum",     64'(bus.sum),     ed ? 64'(m_res[W-1:0]) : 64'(h_sum));
            chk("cout",    64'(bus.cout),    ed ? 64'(m_res[W]) : 64'(h_cout));
            chk("done_id", 64'(bus.done_id), ed ? 64'(m_g) : 64'(h_id));
            chk("add_a",   64'(bus.add_a),   ea);
            chk("add_b",   64'(bus.add_b),   eb);
            chk("add_cin", 64'(bus.add_cin), ec & 64'd1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                return;
            end
        end
        n_chk++;
        n_err++;
        $display("FAIL done_timeout: got no done within 60 cycles, required done");
    endtask

    // Drive one request pattern, wait for done, check literals, release
    // the served requester's req in the DONE cycle.
    task automatic run_op(input string nm, input logic [1:0] r,
                          input logic [W-1:0] a0, b0, input logic c0,
                          input logic [W-1:0] a1, b1, input logic c1,
                          input logic exp_id, input logic [W-1:0] exp_sum,
                          input logic exp_cout);
        int lat;
        @(posedge clk); #3;
        bus.req = r;
        bus.a0 = a0; bus.b0 = b0; bus.cin0 = c0;
        bus.a1 = a1; bus.b1 = b1; bus.cin1 = c1;
        wait_done(lat);
        if (lat < 0) return;
        chk({nm, "_lat"},     64'(lat),         64'(TOT + 1));
        chk({nm, "_sum"},     64'(bus.sum),     64'(exp_sum));
        chk({nm, "_cout"},    64'(bus.cout),    64'(exp_cout));
        chk({nm, "_id"},      64'(bus.done_id), 64'(exp_id));
        chk({nm, "_ack"},     64'(bus.ack),     exp_id ? 64'd2 : 64'd1);
        chk({nm, "_model"},   64'(m_res),       {47'd0, exp_cout, exp_sum});
        bus.req[exp_id] = 1'b0;
    endtask

    initial begin
        int lat;
        bus.req = 2'b00;
        bus.a0 = '0; bus.b0 = '0; bus.cin0 = 1'b0;
        bus.a1 = '0; bus.b1 = '0; bus.cin1 = 1'b0;
        @(posedge clk);
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_sum",  64'(bus.sum),  64'd0);
        chk("rst_ack",  64'(bus.ack),  64'd0);
        #2 rst_n = 1'b1;

        run_op("t1", 2'b01, 16'h1234, 16'h4321, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h5555, 1'b0);
        run_op("t2", 2'b01, 16'hFFFF, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_op("t3", 2'b10, 16'h0, 16'h0, 1'b0, 16'h000F, 16'h0000, 1'b1, 1'b1, 16'h0010, 1'b0);
        repeat (3) @(posedge clk);
        chk("hold_sum", 64'(bus.sum), 64'h0010);
        chk("hold_id",  64'(bus.done_id), 64'd1);

        // Tie right after reset: requester 0 first, then 1, then 0 again.
        @(posedge clk); #3 rst_n = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        run_op("tie0", 2'b11, 16'h0102, 16'h0304, 1'b0, 16'h1000, 16'h2000, 1'b1, 1'b0, 16'h0406, 1'b0);
        run_op("tie1", 2'b10, 16'h0102, 16'h0304, 1'b0, 16'h1000, 16'h2000, 1'b1, 1'b1, 16'h3001, 1'b0);
        run_op("tie2", 2'b11, 16'h00F0, 16'h0F10, 1'b0, 16'h1000, 16'h2000, 1'b1, 1'b0, 16'h1000, 1'b0);
        run_op("tie3", 2'b10, 16'h00F0, 16'h0F10, 1'b0, 16'h1000, 16'h2000, 1'b1, 1'b1, 16'h3001, 1'b0);

        // Reset 7 cycles into ADD with req held.
        @(posedge clk); #3;
        bus.req = 2'b01; bus.a0 = 16'h0ABC; bus.b0 = 16'h1F11; bus.cin0 = 1'b1;
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy",  64'(bus.busy),  64'd0);
        chk("abort_ack",   64'(bus.ack),   64'd0);
        chk("abort_sum",   64'(bus.sum),   64'd0);
        chk("abort_add_a", 64'(bus.add_a), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        wait_done(lat);
        chk("restart_lat", 64'(lat), 64'(TOT + 1));
        chk("restart_sum", 64'(bus.sum), 64'h29CE);
        chk("restart_ack", 64'(bus.ack), 64'd1);
        bus.req = 2'b00;

        // Operands and req changed mid-ADD: latched values still complete.
        @(posedge clk); #3;
        bus.req = 2'b01; bus.a0 = 16'h8888; bus.b0 = 16'h8888; bus.cin0 = 1'b0;
        repeat (6) @(posedge clk);
        #3 bus.req = 2'b00; bus.a0 = 16'h0000;
        wait_done(lat);
        chk("drop_sum",  64'(bus.sum),  64'h1110);
        chk("drop_cout", 64'(bus.cout), 64'd1);
        chk("drop_ack",  64'(bus.ack),  64'd1);
        repeat (4) @(posedge clk);
        #1 chk("drop_idle", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
